// File: rtl/imm_pkg.sv
// Shared opcode constants, format codes and sign-extension helper for the immediate generator.
package imm_pkg;

    localparam logic [4:0] OP_LOAD      = 5'b00000;
    localparam logic [4:0] OP_LOAD_FP   = 5'b00001;
    localparam logic [4:0] OP_OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC     = 5'b00101;
    localparam logic [4:0] OP_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OP_STORE     = 5'b01000;
    localparam logic [4:0] OP_STORE_FP  = 5'b01001;
    localparam logic [4:0] OP_LUI       = 5'b01101;
    localparam logic [4:0] OP_BRANCH    = 5'b11000;
    localparam logic [4:0] OP_JALR      = 5'b11001;
    localparam logic [4:0] OP_JAL       = 5'b11011;
    localparam logic [4:0] OP_SYSTEM    = 5'b11100;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    function automatic logic [63:0] sext64(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decode: inst -> imm, fmt, illegal.
// ZICSR_EN enables the Z format (CSR immediate) for SYSTEM opcodes with funct3[2]=1.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [31:0] raw;
    fmt_e        f;

    // raw is a 32-bit value whose bit 31 is the sign; Z leaves bit 31 clear so widening stays zero-extended
    always_comb begin
        raw     = '0;
        f       = FMT_NONE;
        illegal = (inst[1:0] != 2'b11);
        if (!illegal) begin
            unique case (inst[6:2])
                OP_LUI, OP_AUIPC: begin
                    raw = {inst[31:12], 12'h000};
                    f   = FMT_U;
                end
                OP_JALR, OP_OP_IMM, OP_LOAD, OP_OP_IMM_32, OP_LOAD_FP: begin
                    raw = {{20{inst[31]}}, inst[31:20]};
                    f   = FMT_I;
                end
                OP_STORE, OP_STORE_FP: begin
                    raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                    f   = FMT_S;
                end
                OP_BRANCH: begin
                    raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                    f   = FMT_B;
                end
                OP_JAL: begin
                    raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                    f   = FMT_J;
                end
`ifdef ZICSR_EN
                OP_SYSTEM: begin
                    if (inst[14]) begin
                        raw = {27'd0, inst[19:15]};
                        f   = FMT_Z;
                    end
                end
`else
                OP_SYSTEM: begin
                    raw = '0;
                    f   = FMT_NONE;
                end
`endif
                default: begin
                    raw = '0;
                    f   = FMT_NONE;
                end
            endcase
        end
        fmt = f;
    end

    generate
        if (XLEN == 64) begin : g_x64
            always_comb imm = sext64(raw);
        end else begin : g_x32
            always_comb imm = raw;
        end
    endgenerate

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator with a 2-entry skid buffer and synchronous flush.
// Optional ZICSR_EN macro enables the CSR immediate format in imm_decode.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    state_e           state, state_nxt;
    logic             accept, fire;
    logic             ld_main_in, ld_skid, ld_main_skid;

    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_illegal;
    logic [TAG_W-1:0] skid_tag;

    // Handshakes derive from the registered state only, so in_ready has no path from out_ready
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_skid      = 1'b0;
        ld_main_skid = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt  = ST_ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && fire) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_FULL;
                        ld_skid   = 1'b1;
                    end else if (fire) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (fire) begin
                        state_nxt    = ST_ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm      <= '0;
            out_fmt      <= '0;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
            skid_imm     <= '0;
            skid_fmt     <= '0;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else begin
            if (ld_main_in) begin
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_illegal;
                out_tag     <= in_tag;
            end else if (ld_main_skid) begin
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_illegal;
                out_tag     <= skid_tag;
            end
            if (ld_skid) begin
                skid_imm     <= dec_imm;
                skid_fmt     <= dec_fmt;
                skid_illegal <= dec_illegal;
                skid_tag     <= in_tag;
            end
        end
    end

endmodule
